// File: rtl/stoch_sub_sched.sv
// Round-robin scheduler that time-shares one signed stochastic subtract datapath
// among N_REQ requesters and integrates the datapath output into a signed job result.
module stoch_sub_sched #(
  parameter int N_REQ  = 4,
  parameter int LEN_W  = 10,
  parameter int DP_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ-1:0]       a_p,
  input  logic [N_REQ-1:0]       a_m,
  input  logic [N_REQ-1:0]       b_p,
  input  logic [N_REQ-1:0]       b_m,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [LEN_W:0]         result,
  output logic                   dp_rst,
  output logic                   dp_a_p,
  output logic                   dp_a_m,
  output logic                   dp_b_p,
  output logic                   dp_b_m,
  input  logic                   dp_y_p,
  input  logic                   dp_y_m,
  output logic [2:0]             dbg_state
);

  localparam int PTR_W = $clog2(N_REQ);

  // Handshake: req[i] is held high until done[i] pulses; the requester drives its
  // a/b bits whenever gnt[i] is high, and done[i] is a single-cycle pulse in DONE.
  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PTR_W-1:0]          win_q, win_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                lat_q, lat_d;
  logic signed [LEN_W:0]     acc_q, acc_d;
  logic [LEN_W:0]            result_q, result_d;

  logic                      arb_found;
  logic [PTR_W-1:0]          arb_idx;
  logic                      acc_en;
  logic signed [LEN_W:0]     delta;
  logic [N_REQ-1:0]          win_onehot;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!arb_found && req[(int'(ptr_q) + k) % N_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    delta = '0;
    if (dp_y_p && !dp_y_m) begin
      delta = (LEN_W+1)'(1);
    end else if (dp_y_m && !dp_y_p) begin
      delta = '1;
    end
  end

  // lat_q counts elapsed RUN/DRAIN cycles up to DP_LAT; samples are valid from then on.
  assign acc_en     = (lat_q == 2'(DP_LAT));
  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    acc_d    = acc_q;
    result_d = result_q;
    gnt      = '0;
    done     = '0;
    dp_rst   = 1'b1;
    dp_a_p   = 1'b0;
    dp_a_m   = 1'b0;
    dp_b_p   = 1'b0;
    dp_b_m   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          win_d   = arb_idx;
          ptr_d   = (arb_idx == PTR_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = len[arb_idx*LEN_W +: LEN_W];
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        gnt     = win_onehot;
        acc_d   = '0;
        lat_d   = '0;
        state_d = (cnt_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        gnt    = win_onehot;
        dp_rst = 1'b0;
        dp_a_p = a_p[win_q];
        dp_a_m = a_m[win_q];
        dp_b_p = b_p[win_q];
        dp_b_m = b_m[win_q];
        if (acc_en) begin
          acc_d = acc_q + delta;
        end else begin
          lat_d = lat_q + 2'd1;
        end
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          if (DP_LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = LEN_W'(DP_LAT);
          end
        end
      end
      S_DRAIN: begin
        gnt    = win_onehot;
        dp_rst = 1'b0;
        if (acc_en) begin
          acc_d = acc_q + delta;
        end else begin
          lat_d = lat_q + 2'd1;
        end
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt     = win_onehot;
        done    = win_onehot;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Capture on entry to DONE so result is valid in the same cycle as done.
    if (state_d == S_DONE && state_q != S_DONE) begin
      result_d = acc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stoch_sub_sched.sv
// Directed bench for stoch_sub_sched: two instances (DP_LAT=1 and DP_LAT=0), each
// with a delay-line datapath model y_p=a_p, y_m=b_p.
module tb_stoch_sub_sched;

  localparam int N_REQ = 4;
  localparam int LEN_W = 10;

  logic                   clk;
  logic                   rst;
  logic                   use_z;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] len;
  logic [N_REQ-1:0]       a_p, a_m, b_p, b_m;

  logic [N_REQ-1:0] req_1, req_0;
  logic [N_REQ-1:0] gnt_1, gnt_0, done_1, done_0;
  logic [LEN_W:0]   result_1, result_0;
  logic dp_rst_1, dp_a_p_1, dp_a_m_1, dp_b_p_1, dp_b_m_1, y_p_1, y_m_1;
  logic dp_rst_0, dp_a_p_0, dp_a_m_0, dp_b_p_0, dp_b_m_0;
  logic [2:0] dbg_1, dbg_0;

  logic [N_REQ-1:0] gnt_s, done_s;
  logic [LEN_W:0]   result_s;
  logic             dp_rst_s, dpa_s;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req_1    = use_z ? '0 : req;
  assign req_0    = use_z ? req : '0;
  assign gnt_s    = use_z ? gnt_0 : gnt_1;
  assign done_s   = use_z ? done_0 : done_1;
  assign result_s = use_z ? result_0 : result_1;
  assign dp_rst_s = use_z ? dp_rst_0 : dp_rst_1;
  assign dpa_s    = use_z ? dp_a_p_0 : dp_a_p_1;

  always @(posedge clk) begin
    y_p_1 <= dp_a_p_1;
    y_m_1 <= dp_b_p_1;
  end

  stoch_sub_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .DP_LAT(1)) u_dut (
    .CLK(clk), .RST(rst), .req(req_1), .len(len),
    .a_p(a_p), .a_m(a_m), .b_p(b_p), .b_m(b_m),
    .gnt(gnt_1), .done(done_1), .result(result_1), .dp_rst(dp_rst_1),
    .dp_a_p(dp_a_p_1), .dp_a_m(dp_a_m_1), .dp_b_p(dp_b_p_1), .dp_b_m(dp_b_m_1),
    .dp_y_p(y_p_1), .dp_y_m(y_m_1), .dbg_state(dbg_1)
  );

  stoch_sub_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .DP_LAT(0)) u_dut_z (
    .CLK(clk), .RST(rst), .req(req_0), .len(len),
    .a_p(a_p), .a_m(a_m), .b_p(b_p), .b_m(b_m),
    .gnt(gnt_0), .done(done_0), .result(result_0), .dp_rst(dp_rst_0),
    .dp_a_p(dp_a_p_0), .dp_a_m(dp_a_m_0), .dp_b_p(dp_b_p_0), .dp_b_m(dp_b_m_0),
    .dp_y_p(dp_a_p_0), .dp_y_m(dp_b_p_0), .dbg_state(dbg_0)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one job on requester idx; pattern bit k is the RUN cycle k input.
  // Outside RUN the requester drives a_p=1 so the datapath gating is exercised.
  task automatic run_job(input int idx, input int n, input logic [15:0] apat,
                         input logic [15:0] bpat, input int exp_res, input bit drop);
    int lat   = use_z ? 0 : 1;
    int exp_c = (n == 0) ? 2 : n + lat + 2;
    int gcnt  = 0;
    int dcyc  = -1;
    int k;
    bit run;
    @(posedge clk); #1;
    req = '0;
    req[idx] = 1'b1;
    len[idx*LEN_W +: LEN_W] = LEN_W'(n);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      k   = c - 2;
      run = (k >= 0) && (k < n);
      a_p = '0;
      b_p = '0;
      a_p[idx] = run ? apat[k] : 1'b1;
      b_p[idx] = run ? bpat[k] : 1'b0;
      if (drop && c == 3) req = '0;
      @(negedge clk);
      if (gnt_s != '0) gcnt++;
      if (c == 1) check("gnt_onehot", int'(gnt_s), 1 << idx);
      check("dp_a_p", int'(dpa_s), run ? int'(apat[k]) : 0);
      check("dp_rst", int'(dp_rst_s), (n > 0 && c >= 2 && c <= n + lat + 1) ? 0 : 1);
      if (done_s != '0) begin
        dcyc = c;
        check("done_bit", int'(done_s), 1 << idx);
        req = '0;
        break;
      end
    end
    check("done_cycle", dcyc, exp_c);
    check("gnt_cycles", gcnt, exp_c);
    check("result", int'($signed(result_s)), exp_res);
    @(posedge clk); #1;
    a_p = '0;
    b_p = '0;
    @(negedge clk);
    check("done_once", int'(done_s), 0);
    check("idle_gnt", int'(gnt_s), 0);
  endtask

  task automatic wait_grant(input int exp_idx);
    bit seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt_s != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rr_grant", seen ? int'(gnt_s) : 0, 1 << exp_idx);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_s != '0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b1; use_z = 1'b0; req = '0; len = '0;
    a_p = '0; a_m = '0; b_p = '0; b_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(dbg_1), 0);
    check("rst_gnt", int'(gnt_s), 0);
    check("rst_done", int'(done_s), 0);
    check("rst_result", int'(result_s), 0);
    check("rst_dp_rst", int'(dp_rst_s), 1);
    check("rst_dp_a", int'(dpa_s), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(0, 8, 16'hFFFF, 16'h0000, 8, 1'b0);
    run_job(1, 0, 16'h0000, 16'h0000, 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("result_hold", int'(result_s), 0);
    end
    run_job(2, 5, 16'h0000, 16'h001F, -5, 1'b0);
    check("result_bits", int'(result_s), 11'b111_1111_1011);
    use_z = 1'b1;
    run_job(2, 5, 16'h0000, 16'h001F, -5, 1'b0);
    use_z = 1'b0;
    run_job(3, 4, 16'h000D, 16'h0002, 2, 1'b0);
    run_job(0, 6, 16'h003F, 16'h0000, 6, 1'b1);

    // reset during RUN cycle 3 of a len=8 job on requester 1
    @(posedge clk); #1;
    req = 4'b0010;
    len[LEN_W +: LEN_W] = LEN_W'(8);
    a_p = 4'b0010;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    a_p = '0;
    @(negedge clk);
    check("mid_rst_gnt", int'(gnt_s), 0);
    check("mid_rst_dp_rst", int'(dp_rst_s), 1);
    check("mid_rst_done", int'(done_s), 0);
    check("mid_rst_result", int'(result_s), 0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_s != '0) dn++;
    end
    check("mid_rst_no_done", dn, 0);
    @(posedge clk); #1;
    req = 4'b0110;
    wait_grant(1);
    req = '0;

    // round-robin from a fresh reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) len[i*LEN_W +: LEN_W] = LEN_W'(1);
    req = 4'b1111;
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_grant(3);
    req = 4'b1001;
    wait_grant(0);
    wait_grant(3);
    req = '0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
